// File: rtl/memory_access_unit.sv
// -----------------------------------------------------------------------------
// memory_access_unit
//
// Memory stage sitting right after the execution unit. The ALU result is used
// as the effective address and rs2 as store data. A single access at a time is
// run over a valid/ready request channel and a valid-only response channel;
// the pipeline is stalled until the access completes. Store data is replicated
// across byte/halfword lanes; load data is lane-extracted and sign- or
// zero-extended.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   load, store, funct3   decoded memory controls (load wins if both are set)
//   address, store_data   effective address and rs2 value
//   mem_req_*             request channel (valid/ready), word-aligned address
//   mem_resp_valid/data   read response, only honoured while waiting for it
//   load_data, load_valid extended load result and its one-cycle strobe
//   stall                 holds the pipeline/PC while an access is in progress
//   misaligned            one-cycle strobe for a trapped misaligned access
//
// Build option
//   MISALIGN_TRAP_EN  defined   : misaligned accesses issue no request and
//                                 pulse `misaligned` instead.
//                     undefined : offending low address bits are cleared and
//                                 the access proceeds; `misaligned` is 0.
// -----------------------------------------------------------------------------
module memory_access_unit #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      store,
  input  logic [2:0]                funct3,
  input  logic [ADDRESS_BITS-1:0]   address,
  input  logic [DATA_WIDTH-1:0]     store_data,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_write,
  output logic [ADDRESS_BITS-1:0]   mem_req_addr,
  output logic [DATA_WIDTH/8-1:0]   mem_req_byte_en,
  output logic [DATA_WIDTH-1:0]     mem_req_wdata,
  input  logic                      mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_resp_data,
  output logic [DATA_WIDTH-1:0]     load_data,
  output logic                      load_valid,
  output logic                      stall,
  output logic                      misaligned
);

  localparam int BE_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                    state_q, state_d;
  logic                      is_load_q, is_load_d;
  logic                      write_q, write_d;
  logic [2:0]                funct3_q, funct3_d;
  logic [1:0]                lane_q, lane_d;
  logic [ADDRESS_BITS-1:0]   req_addr_q, req_addr_d;
  logic [BE_W-1:0]           byte_en_q, byte_en_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     load_data_q, load_data_d;

  // The core index only identifies the instance; it does not affect logic.
  logic unused_core;
  assign unused_core = (CORE < 0);

  // ---------------------------------------------------------------------------
  // Request formatting from the incoming instruction
  // ---------------------------------------------------------------------------
  logic [1:0]            lane_in;
  logic [BE_W-1:0]       byte_en_in;
  logic [DATA_WIDTH-1:0] wdata_in;

  // Lane offset with the misaligned low bits already cleared, so that in the
  // non-trapping build a misaligned half/word falls back to its aligned slot.
  always_comb begin
    lane_in    = 2'b00;
    byte_en_in = '1;
    wdata_in   = store_data;
    case (funct3[1:0])
      2'b00: begin
        lane_in    = address[1:0];
        byte_en_in = {{(BE_W-1){1'b0}}, 1'b1} << lane_in;
        wdata_in   = {BE_W{store_data[7:0]}};
      end
      2'b01: begin
        lane_in    = {address[1], 1'b0};
        byte_en_in = {{(BE_W-2){1'b0}}, 2'b11} << lane_in;
        wdata_in   = {(DATA_WIDTH/16){store_data[15:0]}};
      end
      default: begin
        lane_in    = 2'b00;
        byte_en_in = '1;
        wdata_in   = store_data;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned_q, misaligned_d;
  logic mis_in;
  assign mis_in = ((funct3[1:0] == 2'b01) && address[0]) ||
                  (funct3[1] && (address[1:0] != 2'b00));
`endif

  // ---------------------------------------------------------------------------
  // Load data extraction: bring the addressed lane down to bit 0, then extend
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_fmt;

  always_comb begin
    shifted  = mem_resp_data >> {lane_q, 3'b000};
    load_fmt = shifted;
    case (funct3_q[1:0])
      2'b00:   load_fmt = {{(DATA_WIDTH-8){~funct3_q[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   load_fmt = {{(DATA_WIDTH-16){~funct3_q[2] & shifted[15]}}, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM next state and register updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    is_load_d   = is_load_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    req_addr_d  = req_addr_q;
    byte_en_d   = byte_en_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
`ifdef MISALIGN_TRAP_EN
    misaligned_d = misaligned_q;
`endif
    case (state_q)
      IDLE: begin
        if (load || store) begin
          // A simultaneous load and store is treated as a load.
          is_load_d  = load;
          write_d    = ~load;
          funct3_d   = funct3;
          lane_d     = lane_in;
          req_addr_d = {address[ADDRESS_BITS-1:2], 2'b00};
          byte_en_d  = byte_en_in;
          wdata_d    = wdata_in;
`ifdef MISALIGN_TRAP_EN
          misaligned_d = mis_in;
          state_d      = mis_in ? DONE : REQ;
`else
          state_d      = REQ;
`endif
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = write_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          load_data_d = load_fmt;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      is_load_q   <= 1'b0;
      write_q     <= 1'b0;
      funct3_q    <= 3'b000;
      lane_q      <= 2'b00;
      req_addr_q  <= '0;
      byte_en_q   <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      is_load_q   <= is_load_d;
      write_q     <= write_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      req_addr_q  <= req_addr_d;
      byte_en_q   <= byte_en_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_req_valid   = (state_q == REQ);
  assign mem_req_write   = write_q;
  assign mem_req_addr    = req_addr_q;
  assign mem_req_byte_en = byte_en_q;
  assign mem_req_wdata   = wdata_q;
  assign load_data       = load_data_q;
  assign stall           = ((state_q == IDLE) && (load || store)) ||
                           (state_q == REQ) || (state_q == WAIT);

`ifdef MISALIGN_TRAP_EN
  assign load_valid = (state_q == DONE) && is_load_q && ~misaligned_q;
  assign misaligned = (state_q == DONE) && misaligned_q;
`else
  assign load_valid = (state_q == DONE) && is_load_q;
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit. Expected requests and load
// results are queued when an access is launched and compared by a monitor
// when the DUT handshakes a request or strobes load_valid.
module tb_memory_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        load, store;
  logic [2:0]  funct3;
  logic [19:0] address;
  logic [31:0] store_data;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [19:0] mem_req_addr;
  logic [3:0]  mem_req_byte_en;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic [31:0] load_data;
  logic        load_valid, stall, misaligned;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [19:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        write;
  } req_t;

  req_t        exp_req_q[$];
  logic [31:0] exp_load_q[$];
  logic        prev_pending = 1'b0;

  memory_access_unit #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20)) dut (
    .clock(clock), .reset(reset), .load(load), .store(store), .funct3(funct3),
    .address(address), .store_data(store_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_byte_en(mem_req_byte_en), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .load_data(load_data), .load_valid(load_valid), .stall(stall),
    .misaligned(misaligned)
  );

  always #5 clock = ~clock;

  function automatic req_t mk_req(input logic [19:0] a, input logic [3:0] be,
                                  input logic [31:0] wd, input logic wr);
    req_t r;
    r.addr = a; r.be = be; r.wdata = wd; r.write = wr;
    return r;
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clock) begin
    req_t e;
    logic [31:0] el;
    if (reset) begin
      prev_pending = 1'b0;
    end else begin
      if (prev_pending) begin
        checks++;
        if (!mem_req_valid) begin
          failures++;
          $display("FAIL valid_dropped actual=0 required=1");
        end
      end
      prev_pending = mem_req_valid && !mem_req_ready;
      if (mem_req_valid && mem_req_ready) begin
        checks++;
        if (exp_req_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_req actual addr=%h be=%b write=%b required=none",
                   mem_req_addr, mem_req_byte_en, mem_req_write);
        end else begin
          e = exp_req_q.pop_front();
          if (mem_req_addr !== e.addr || mem_req_byte_en !== e.be ||
              mem_req_write !== e.write || (e.write && mem_req_wdata !== e.wdata)) begin
            failures++;
            $display("FAIL req actual addr=%h be=%b wdata=%h write=%b required addr=%h be=%b wdata=%h write=%b",
                     mem_req_addr, mem_req_byte_en, mem_req_wdata, mem_req_write,
                     e.addr, e.be, e.wdata, e.write);
          end else begin
            $display("req  addr=%h be=%b wdata=%h write=%b ok",
                     mem_req_addr, mem_req_byte_en, mem_req_wdata, mem_req_write);
          end
        end
      end
      if (load_valid) begin
        checks++;
        if (exp_load_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_load actual=%h required=none", load_data);
        end else begin
          el = exp_load_q.pop_front();
          if (load_data !== el) begin
            failures++;
            $display("FAIL load_data actual=%h required=%h", load_data, el);
          end else begin
            $display("load data=%h ok", load_data);
          end
        end
      end
    end
  end

  // Drives one access over a fixed 10-cycle window and reports what was seen.
  task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [19:0] a, input logic [31:0] sd,
                            input int ready_cyc, input int resp_cyc,
                            input logic [31:0] rd,
                            output int stall_cnt, output int valid_cnt,
                            output int lv_cyc, output int mis_cnt,
                            output logic addr_stable);
    logic [19:0] first_addr;
    logic        seen;
    stall_cnt = 0; valid_cnt = 0; lv_cyc = -1; mis_cnt = 0;
    addr_stable = 1'b1; seen = 1'b0; first_addr = '0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge clock); #1;
      load           = ld && (cyc == 0);
      store          = st && (cyc == 0);
      funct3         = f3;
      address        = a;
      store_data     = sd;
      mem_req_ready  = (cyc >= ready_cyc);
      mem_resp_valid = (cyc == resp_cyc);
      mem_resp_data  = (cyc == resp_cyc) ? rd : $urandom;
      @(negedge clock);
      if (stall) stall_cnt++;
      if (misaligned) mis_cnt++;
      if (load_valid && lv_cyc < 0) lv_cyc = cyc;
      if (mem_req_valid) begin
        valid_cnt++;
        if (seen && mem_req_addr !== first_addr) addr_stable = 1'b0;
        first_addr = mem_req_addr;
        seen = 1'b1;
      end
    end
    @(posedge clock); #1;
    load = 0; store = 0; mem_req_ready = 0; mem_resp_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1; load = 0; store = 0; funct3 = 0; address = 0; store_data = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({mem_req_valid, mem_req_write, mem_req_addr, mem_req_byte_en, mem_req_wdata,
         load_data, load_valid, misaligned, stall} !== '0) begin
      failures++;
      $display("FAIL reset_outputs actual valid=%b write=%b addr=%h be=%b wdata=%h ld=%h lv=%b mis=%b stall=%b required all 0",
               mem_req_valid, mem_req_write, mem_req_addr, mem_req_byte_en, mem_req_wdata,
               load_data, load_valid, misaligned, stall);
    end
    @(posedge clock); #1; load = 1;
    @(negedge clock);
    checks++;
    if (stall !== 1'b1 || mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall actual stall=%b valid=%b required stall=1 valid=0", stall, mem_req_valid);
    end
    @(posedge clock); #1; load = 0;
    @(posedge clock); #1; reset = 0;
    $display("reset done");
  endtask

  task automatic test_sb();
    int s, v, lv, m; logic st;
    exp_req_q.push_back(mk_req(20'h00100, 4'b1000, 32'hA5A5A5A5, 1'b1));
    run_access(1'b0, 1'b1, 3'b000, 20'h00103, 32'h000000A5, 0, -1, 32'h0, s, v, lv, m, st);
    checks++;
    if (s != 2 || v != 1 || lv != -1) begin
      failures++;
      $display("FAIL sb_timing actual stall=%0d valid=%0d lv=%0d required stall=2 valid=1 lv=-1", s, v, lv);
    end
  endtask

  task automatic test_loads_byte();
    int s, v, lv, m; logic st;
    exp_req_q.push_back(mk_req(20'h00100, 4'b0100, 32'h0, 1'b0));
    exp_load_q.push_back(32'hFFFFFFF4);
    run_access(1'b1, 1'b0, 3'b000, 20'h00102, 32'h0, 1, 2, 32'h12F45678, s, v, lv, m, st);
    checks++;
    if (lv != 3 || s != 3) begin
      failures++;
      $display("FAIL lb_timing actual lv_cyc=%0d stall=%0d required lv_cyc=3 stall=3", lv, s);
    end
    exp_req_q.push_back(mk_req(20'h00100, 4'b0100, 32'h0, 1'b0));
    exp_load_q.push_back(32'h000000F4);
    run_access(1'b1, 1'b0, 3'b100, 20'h00102, 32'h0, 1, 2, 32'h12F45678, s, v, lv, m, st);
    checks++;
    if (lv != 3) begin
      failures++;
      $display("FAIL lbu_timing actual lv_cyc=%0d required=3", lv);
    end
  endtask

  task automatic test_lh_backpressure();
    int s, v, lv, m; logic st;
    exp_req_q.push_back(mk_req(20'h00100, 4'b1100, 32'h0, 1'b0));
    exp_load_q.push_back(32'hFFFF8001);
    run_access(1'b1, 1'b0, 3'b001, 20'h00102, 32'h0, 4, 5, 32'h80017FFF, s, v, lv, m, st);
    checks++;
    if (v != 4 || st !== 1'b1 || lv != 6) begin
      failures++;
      $display("FAIL lh_hold actual valid=%0d stable=%b lv=%0d required valid=4 stable=1 lv=6", v, st, lv);
    end
  endtask

  task automatic test_misaligned_lw();
    int s, v, lv, m; logic st;
`ifdef MISALIGN_TRAP_EN
    run_access(1'b1, 1'b0, 3'b010, 20'h00202, 32'h0, 0, 1, 32'h13572468, s, v, lv, m, st);
    checks++;
    if (v != 0 || m != 1 || lv != -1 || s != 1) begin
      failures++;
      $display("FAIL lw_trap actual valid=%0d mis=%0d lv=%0d stall=%0d required 0 1 -1 1", v, m, lv, s);
    end
`else
    exp_req_q.push_back(mk_req(20'h00200, 4'b1111, 32'h0, 1'b0));
    exp_load_q.push_back(32'hCAFEF00D);
    run_access(1'b1, 1'b0, 3'b010, 20'h00202, 32'h0, 1, 2, 32'hCAFEF00D, s, v, lv, m, st);
    checks++;
    if (v != 1 || m != 0 || lv != 3) begin
      failures++;
      $display("FAIL lw_align actual valid=%0d mis=%0d lv=%0d required 1 0 3", v, m, lv);
    end
`endif
  endtask

  task automatic test_reset_in_wait();
    int lv_seen;
    lv_seen = 0;
    exp_req_q.push_back(mk_req(20'h00100, 4'b1111, 32'h0, 1'b0));
    @(posedge clock); #1; load = 1; funct3 = 3'b010; address = 20'h00100; mem_req_ready = 1;
    @(posedge clock); #1; load = 0;
    @(posedge clock); #1; reset = 1; mem_req_ready = 0;
    @(posedge clock); #1; reset = 0; mem_resp_valid = 1; mem_resp_data = 32'h55AA55AA;
    @(negedge clock);
    checks++;
    if ({mem_req_valid, mem_req_write, mem_req_addr, mem_req_byte_en, mem_req_wdata,
         load_data, load_valid, misaligned, stall} !== '0) begin
      failures++;
      $display("FAIL reset_wait_outputs actual valid=%b write=%b addr=%h be=%b wdata=%h ld=%h lv=%b mis=%b stall=%b required all 0",
               mem_req_valid, mem_req_write, mem_req_addr, mem_req_byte_en, mem_req_wdata,
               load_data, load_valid, misaligned, stall);
    end
    @(posedge clock); #1; mem_resp_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (load_valid || mem_req_valid) lv_seen++;
    end
    checks++;
    if (lv_seen != 0) begin
      failures++;
      $display("FAIL reset_wait_drop actual=%0d strobes required=0", lv_seen);
    end
  endtask

  task automatic test_load_and_store();
    int s, v, lv, m; logic st;
    exp_req_q.push_back(mk_req(20'h00010, 4'b1111, 32'h0, 1'b0));
    exp_load_q.push_back(32'h0BADF00D);
    run_access(1'b1, 1'b1, 3'b010, 20'h00010, 32'h11223344, 1, 2, 32'h0BADF00D, s, v, lv, m, st);
    checks++;
    if (v != 1 || lv != 3) begin
      failures++;
      $display("FAIL ld_st_both actual valid=%0d lv=%0d required 1 3", v, lv);
    end
  endtask

  task automatic test_back_to_back();
    int s, v, lv, m; logic st;
    exp_req_q.push_back(mk_req(20'h00104, 4'b1100, 32'hBEEFBEEF, 1'b1));
    run_access(1'b0, 1'b1, 3'b001, 20'h00106, 32'h1234BEEF, 0, -1, 32'h0, s, v, lv, m, st);
    exp_req_q.push_back(mk_req(20'h00208, 4'b1111, 32'hDEADBEEF, 1'b1));
    run_access(1'b0, 1'b1, 3'b010, 20'h00208, 32'hDEADBEEF, 2, -1, 32'h0, s, v, lv, m, st);
    checks++;
    if (s != 3 || v != 2) begin
      failures++;
      $display("FAIL sw_wait actual stall=%0d valid=%0d required 3 2", s, v);
    end
  endtask

  initial begin
    test_reset();
    test_sb();
    test_loads_byte();
    test_lh_backpressure();
    test_misaligned_lw();
    test_reset_in_wait();
    test_load_and_store();
    test_back_to_back();
    repeat (3) @(posedge clock);
    checks++;
    if (exp_req_q.size() != 0) begin
      failures++;
      $display("FAIL req_queue_leftover actual=%0d required=0", exp_req_q.size());
    end
    checks++;
    if (exp_load_q.size() != 0) begin
      failures++;
      $display("FAIL load_queue_leftover actual=%0d required=0", exp_load_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
